// File: rtl/bluejay_pkg.sv
// ---------------------------------------------------------------------------
// bluejay_pkg
// Shared types and constants for the Bluejay SLM data receiver.
//   state_t        : receiver state (IDLE, LINE, GAP, UPDATE)
//   DEFAULT_*      : default geometry of the SLM line/frame
//   ERR_*          : bit positions inside the sticky err_o vector
// ---------------------------------------------------------------------------
package bluejay_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LINE   = 2'd1,
        GAP    = 2'd2,
        UPDATE = 2'd3
    } state_t;

    localparam int DEFAULT_WORDS_PER_LINE  = 40;
    localparam int DEFAULT_LINES_PER_FRAME = 1024;

    localparam int ERR_W      = 5;
    localparam int ERR_SYNC   = 0;
    localparam int ERR_VALID  = 1;
    localparam int ERR_UPDATE = 2;
    localparam int ERR_SHORT  = 3;
    localparam int ERR_LONG   = 4;

endpackage

// File: rtl/bluejay_busy_timer.sv
// ---------------------------------------------------------------------------
// bluejay_busy_timer
// Loadable down-counter that models how long the display stays busy.
// Loading N makes done_o read low for N-1 cycles and high on the N-th cycle
// after the load edge, so a state that waits for done_o lasts exactly N
// cycles. N must be at least 1.
// Ports:
//   clk_i      : clock
//   reset_i    : asynchronous active-high reset
//   load_i     : restart the count with cycles_i
//   cycles_i   : busy length in cycles
//   done_o     : count has expired
// ---------------------------------------------------------------------------
module bluejay_busy_timer #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] cycles_i,
    output logic         done_o
);

    logic [W-1:0] count;

    // Counts down to zero and parks there until the next load.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count <= '0;
        end else if (load_i) begin
            count <= cycles_i - W'(1);
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done_o = (count == '0);

endmodule

// File: rtl/bluejay_data_rx.sv
// ---------------------------------------------------------------------------
// bluejay_data_rx
// Display-side receiver for the Bluejay SLM line/frame data interface.
// Captures each line of words into a line-buffer write port, counts lines per
// frame, models display busy time after each line and each frame update, and
// records protocol violations in sticky error bits.
//
// Optional feature: define BLUEJAY_DATA_RX_CHECKSUM_EN to produce an XOR
// checksum of all words written during a frame on frame_sum_o. Without it,
// frame_sum_o is tied to zero.
//
// Ports:
//   clk_i, reset_i    : clock, asynchronous active-high reset
//   data_i, valid_i   : line data word and its qualifier
//   sync_i            : start-of-line strobe
//   update_i          : end-of-frame / latch strobe
//   clr_err_i         : synchronous clear of err_o
//   next_line_rdy_o   : receiver idle and ready for a new line
//   line_wr_o         : line-buffer write strobe
//   line_addr_o       : word index inside the line
//   line_data_o       : captured word
//   line_cnt_o        : lines received in the current frame
//   frame_done_o      : one-cycle pulse on an accepted update
//   err_o             : sticky errors {long, short, update, valid, sync}
//   frame_sum_o       : frame checksum (optional feature)
// ---------------------------------------------------------------------------
module bluejay_data_rx
    import bluejay_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int WORDS_PER_LINE  = DEFAULT_WORDS_PER_LINE,
    parameter int LINES_PER_FRAME = DEFAULT_LINES_PER_FRAME,
    parameter int LINE_GAP        = 8,
    parameter int UPDATE_CYCLES   = 16,
    localparam int ADDR_W         = $clog2(WORDS_PER_LINE),
    localparam int CNT_W          = $clog2(LINES_PER_FRAME + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              sync_i,
    input  logic              valid_i,
    input  logic              update_i,
    input  logic              clr_err_i,
    output logic              next_line_rdy_o,
    output logic              line_wr_o,
    output logic [ADDR_W-1:0] line_addr_o,
    output logic [DATA_W-1:0] line_data_o,
    output logic [CNT_W-1:0]  line_cnt_o,
    output logic              frame_done_o,
    output logic [ERR_W-1:0]  err_o,
    output logic [DATA_W-1:0] frame_sum_o
);

    localparam int TIMER_MAX = (LINE_GAP > UPDATE_CYCLES) ? LINE_GAP : UPDATE_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORDS_PER_LINE - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(LINES_PER_FRAME);

    state_t             state;
    logic [ADDR_W-1:0]  word_idx;
    logic               word_accept;
    logic               last_word;
    logic               accept_update;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_cycles;
    logic               timer_done;
    logic [ERR_W-1:0]   err_new;

    // A word is only taken while a line is open; the final word of a line
    // and an update accepted in IDLE both (re)start the shared busy timer.
    assign word_accept   = (state == LINE) && valid_i;
    assign last_word     = word_accept && (word_idx == LAST_IDX);
    assign accept_update = (state == IDLE) && update_i;
    assign timer_load    = last_word || accept_update;
    assign timer_cycles  = accept_update ? TIMER_W'(UPDATE_CYCLES) : TIMER_W'(LINE_GAP);

    bluejay_busy_timer #(
        .W (TIMER_W)
    ) u_busy_timer (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .load_i   (timer_load),
        .cycles_i (timer_cycles),
        .done_o   (timer_done)
    );

    // Protocol violations seen this cycle. In IDLE an update takes priority
    // over a simultaneous sync, so the sync is the one reported; the
    // long-frame error only applies to a sync that was otherwise alone.
    always_comb begin
        err_new = '0;
        case (state)
            IDLE: begin
                if (update_i) begin
                    err_new[ERR_SYNC]  = sync_i;
                    err_new[ERR_SHORT] = (line_cnt_o != FULL_CNT);
                end else if (sync_i && (line_cnt_o == FULL_CNT)) begin
                    err_new[ERR_LONG] = 1'b1;
                end
                err_new[ERR_VALID] = valid_i;
            end
            LINE: begin
                err_new[ERR_SYNC]   = sync_i;
                err_new[ERR_UPDATE] = update_i;
            end
            GAP, UPDATE: begin
                err_new[ERR_SYNC]   = sync_i;
                err_new[ERR_UPDATE] = update_i;
                err_new[ERR_VALID]  = valid_i;
            end
            default: err_new = '0;
        endcase
    end

    // Main receiver FSM with all outputs registered. next_line_rdy_o is
    // driven from the state being entered so it is high exactly while the
    // receiver sits in IDLE.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state           <= IDLE;
            word_idx        <= '0;
            next_line_rdy_o <= 1'b0;
            line_wr_o       <= 1'b0;
            line_addr_o     <= '0;
            line_data_o     <= '0;
            line_cnt_o      <= '0;
            frame_done_o    <= 1'b0;
            err_o           <= '0;
        end else begin
            line_wr_o    <= 1'b0;
            frame_done_o <= 1'b0;
            err_o        <= (clr_err_i ? '0 : err_o) | err_new;

            case (state)
                IDLE: begin
                    if (update_i) begin
                        state           <= UPDATE;
                        line_cnt_o      <= '0;
                        frame_done_o    <= 1'b1;
                        next_line_rdy_o <= 1'b0;
                    end else if (sync_i && (line_cnt_o < FULL_CNT)) begin
                        state           <= LINE;
                        word_idx        <= '0;
                        next_line_rdy_o <= 1'b0;
                    end else begin
                        next_line_rdy_o <= 1'b1;
                    end
                end
                LINE: begin
                    if (valid_i) begin
                        line_wr_o   <= 1'b1;
                        line_addr_o <= word_idx;
                        line_data_o <= data_i;
                        word_idx    <= word_idx + ADDR_W'(1);
                        if (last_word) begin
                            state <= GAP;
                            if (line_cnt_o != FULL_CNT) begin
                                line_cnt_o <= line_cnt_o + CNT_W'(1);
                            end
                        end
                    end
                end
                GAP, UPDATE: begin
                    if (timer_done) begin
                        state           <= IDLE;
                        next_line_rdy_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BLUEJAY_DATA_RX_CHECKSUM_EN
    logic [DATA_W-1:0] sum_acc;

    // Running XOR of written words; handed to frame_sum_o and restarted on
    // the same edge that raises frame_done_o. No word can be accepted on an
    // update edge, so nothing is lost at the hand-over.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sum_acc     <= '0;
            frame_sum_o <= '0;
        end else if (accept_update) begin
            frame_sum_o <= sum_acc;
            sum_acc     <= '0;
        end else if (word_accept) begin
            sum_acc <= sum_acc ^ data_i;
        end
    end
`else
    assign frame_sum_o = '0;
`endif

endmodule

// File: tb/tb_bluejay_data_rx.sv
// ---------------------------------------------------------------------------
// tb_bluejay_data_rx
// Directed bench for bluejay_data_rx with a small geometry (4 words per line,
// 2 lines per frame, 3-cycle line gap, 5-cycle update). Expected writes and
// frame-done events are queued as stimulus is issued; a negedge monitor
// compares them against what the receiver presents.
// ---------------------------------------------------------------------------
module tb_bluejay_data_rx;

    localparam int DATA_W = 32;
    localparam int WPL    = 4;
    localparam int LPF    = 2;
    localparam int GAPC   = 3;
    localparam int UPDC   = 5;

    logic              clock    = 1'b0;
    logic              reset    = 1'b1;
    logic [DATA_W-1:0] dataIn   = '0;
    logic              syncIn   = 1'b0;
    logic              validIn  = 1'b0;
    logic              updateIn = 1'b0;
    logic              clrErrIn = 1'b0;

    logic              nextLineRdy;
    logic              lineWr;
    logic [1:0]        lineAddr;
    logic [DATA_W-1:0] lineData;
    logic [1:0]        lineCnt;
    logic              frameDone;
    logic [4:0]        errOut;
    logic [DATA_W-1:0] frameSum;

    int compareCount  = 0;
    int mismatchCount = 0;

    typedef struct packed {
        logic [1:0]        addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               expWrQ[$];
    logic [DATA_W-1:0] expSumQ[$];
    logic [DATA_W-1:0] sumModel = '0;
    wr_t               popWr;
    logic [DATA_W-1:0] popSum;

    bluejay_data_rx #(
        .DATA_W          (DATA_W),
        .WORDS_PER_LINE  (WPL),
        .LINES_PER_FRAME (LPF),
        .LINE_GAP        (GAPC),
        .UPDATE_CYCLES   (UPDC)
    ) dut (
        .clk_i           (clock),
        .reset_i         (reset),
        .data_i          (dataIn),
        .sync_i          (syncIn),
        .valid_i         (validIn),
        .update_i        (updateIn),
        .clr_err_i       (clrErrIn),
        .next_line_rdy_o (nextLineRdy),
        .line_wr_o       (lineWr),
        .line_addr_o     (lineAddr),
        .line_data_o     (lineData),
        .line_cnt_o      (lineCnt),
        .frame_done_o    (frameDone),
        .err_o           (errOut),
        .frame_sum_o     (frameSum)
    );

    always #5 clock = ~clock;

    // Global time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever the receiver writes a
    // word or pulses frame_done_o.
    always @(negedge clock) begin
        if (!reset) begin
            if (lineWr) begin
                if (expWrQ.size() == 0) begin
                    checkOutput("unexpected_write", {31'd0, lineWr}, 32'd0);
                end else begin
                    popWr = expWrQ.pop_front();
                    checkOutput("write_addr", {30'd0, lineAddr}, {30'd0, popWr.addr});
                    checkOutput("write_data", lineData, popWr.data);
                end
            end
            if (frameDone) begin
                if (expSumQ.size() == 0) begin
                    checkOutput("unexpected_frame_done", {31'd0, frameDone}, 32'd0);
                end else begin
                    popSum = expSumQ.pop_front();
                    checkOutput("frame_sum", frameSum, popSum);
                end
            end
        end
    end

    task automatic stepIdle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Drives one cycle of inputs; returns 1 time unit after the sampling edge.
    task automatic applyStimulus(input logic s, input logic v, input logic u,
                                 input logic c, input logic [DATA_W-1:0] d);
        syncIn   = s;
        validIn  = v;
        updateIn = u;
        clrErrIn = c;
        dataIn   = d;
        @(posedge clock);
        #1;
        syncIn   = 1'b0;
        validIn  = 1'b0;
        updateIn = 1'b0;
        clrErrIn = 1'b0;
        dataIn   = '0;
    endtask

    task automatic pushWrite(input logic [1:0] a, input logic [DATA_W-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        expWrQ.push_back(e);
        sumModel = sumModel ^ d;
    endtask

    task automatic pushFrameDone();
`ifdef BLUEJAY_DATA_RX_CHECKSUM_EN
        expSumQ.push_back(sumModel);
`else
        expSumQ.push_back('0);
`endif
        sumModel = '0;
    endtask

    task automatic sendWord(input logic [1:0] a, input logic [DATA_W-1:0] d);
        pushWrite(a, d);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, d);
    endtask

    // Sync followed by four words; spacing idle cycles between words.
    task automatic sendLine(input logic [4*DATA_W-1:0] words, input int spacing);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < WPL; i++) begin
            sendWord(2'(i), words[DATA_W*i +: DATA_W]);
            if (spacing > 0 && i < WPL - 1) stepIdle(spacing);
        end
    endtask

    task automatic waitReady(input string name);
        int budget = 0;
        while (!nextLineRdy && budget < 50) begin
            stepIdle(1);
            budget++;
        end
        checkOutput(name, {31'd0, nextLineRdy}, 32'd1);
    endtask

    initial begin
        $display("[TB] start");

        // Reset state
        stepIdle(3);
        checkOutput("rst_wr", {31'd0, lineWr}, 32'd0);
        checkOutput("rst_rdy", {31'd0, nextLineRdy}, 32'd0);
        checkOutput("rst_cnt", {30'd0, lineCnt}, 32'd0);
        checkOutput("rst_err", {27'd0, errOut}, 32'd0);
        checkOutput("rst_done", {31'd0, frameDone}, 32'd0);
        checkOutput("rst_sum", frameSum, 32'd0);
        reset = 1'b0;
        checkOutput("rel_rdy_before_edge", {31'd0, nextLineRdy}, 32'd0);
        stepIdle(1);
        checkOutput("rel_rdy_after_edge", {31'd0, nextLineRdy}, 32'd1);

        // 1. Nominal line, rdy back 4 cycles after the last valid
        sendLine({32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0);
        checkOutput("t1_cnt", {30'd0, lineCnt}, 32'd1);
        checkOutput("t1_rdy_gap1", {31'd0, nextLineRdy}, 32'd0);
        stepIdle(2);
        checkOutput("t1_rdy_gap3", {31'd0, nextLineRdy}, 32'd0);
        stepIdle(1);
        checkOutput("t1_rdy_back", {31'd0, nextLineRdy}, 32'd1);

        // 2. Second line completes the frame, then update
        sendLine({32'hB8, 32'hB4, 32'hB2, 32'hB1}, 0);
        checkOutput("t2_cnt_full", {30'd0, lineCnt}, 32'd2);
        waitReady("t2_rdy_line2");
        pushFrameDone();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
        checkOutput("t2_cnt_cleared", {30'd0, lineCnt}, 32'd0);
        checkOutput("t2_rdy_upd1", {31'd0, nextLineRdy}, 32'd0);
        checkOutput("t2_err", {27'd0, errOut}, 32'd0);
        stepIdle(4);
        checkOutput("t2_rdy_upd5", {31'd0, nextLineRdy}, 32'd0);
        stepIdle(1);
        checkOutput("t2_rdy_back", {31'd0, nextLineRdy}, 32'd1);

        // 3. Short frame
        sendLine({32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000}, 0);
        waitReady("t3_rdy_line");
        pushFrameDone();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
        checkOutput("t3_err_short", {27'd0, errOut}, 32'h08);
        waitReady("t3_rdy_upd");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
        checkOutput("t3_err_clr", {27'd0, errOut}, 32'd0);

        // 4. Violations
        sendLine({32'hD3, 32'hD2, 32'hD1, 32'hD0}, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD);
        checkOutput("t4_err_valid_gap", {27'd0, errOut}, 32'h02);
        waitReady("t4_rdy_line1");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        sendWord(2'd0, 32'hE0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("t4_err_sync_line", {27'd0, errOut}, 32'h03);
        sendWord(2'd1, 32'hE1);
        sendWord(2'd2, 32'hE2);
        sendWord(2'd3, 32'hE3);
        checkOutput("t4_cnt_full", {30'd0, lineCnt}, 32'd2);
        waitReady("t4_rdy_line2");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("t4_err_long", {27'd0, errOut}, 32'h13);
        checkOutput("t4_rdy_stays", {31'd0, nextLineRdy}, 32'd1);
        checkOutput("t4_cnt_sat", {30'd0, lineCnt}, 32'd2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h55);
        checkOutput("t4_err_clr_vs_new", {27'd0, errOut}, 32'h02);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
        checkOutput("t4_err_clr", {27'd0, errOut}, 32'd0);
        pushFrameDone();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
        checkOutput("t4_err_full_frame", {27'd0, errOut}, 32'd0);
        waitReady("t4_rdy_upd");

        // 5. Gapped valids
        sendLine({32'hF3, 32'hF2, 32'hF1, 32'hF0}, 1);
        checkOutput("t5_cnt", {30'd0, lineCnt}, 32'd1);
        waitReady("t5_rdy");

        // 6. Reset mid-line
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        sendWord(2'd0, 32'h60);
        sendWord(2'd1, 32'h61);
        sendWord(2'd2, 32'h62);
        @(negedge clock);
        #1;
        reset = 1'b1;
        sumModel = '0;
        #1;
        checkOutput("t6_wr_in_rst", {31'd0, lineWr}, 32'd0);
        checkOutput("t6_addr_in_rst", {30'd0, lineAddr}, 32'd0);
        checkOutput("t6_data_in_rst", lineData, 32'd0);
        checkOutput("t6_cnt_in_rst", {30'd0, lineCnt}, 32'd0);
        checkOutput("t6_rdy_in_rst", {31'd0, nextLineRdy}, 32'd0);
        validIn = 1'b1;
        dataIn  = 32'h63;
        stepIdle(2);
        validIn = 1'b0;
        dataIn  = '0;
        reset   = 1'b0;
        stepIdle(1);
        checkOutput("t6_rdy_after_rel", {31'd0, nextLineRdy}, 32'd1);
        checkOutput("t6_err_after_rel", {27'd0, errOut}, 32'd0);
        sendLine({32'h14, 32'h13, 32'h12, 32'h11}, 0);
        checkOutput("t6_cnt", {30'd0, lineCnt}, 32'd1);
        waitReady("t6_rdy");
        stepIdle(2);

        checkOutput("wr_queue_drained", 32'(expWrQ.size()), 32'd0);
        checkOutput("done_queue_drained", 32'(expSumQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/bluejay_data_rx.md
Name: bluejay_data_rx

Overview:
- Display-side receiver for the Bluejay SLM line/frame data interface: the sink end of the data path that drives data/sync/valid/update and waits on next-line-ready.
- Captures each line of 32-bit words into a line-buffer write port.
- Counts lines per frame and models display busy time after each line and each frame update.
- Flags protocol violations in sticky error bits.
- Used in simulation as a display model and on-board as a loop-back checker.

Parameters:
- DATA_W, 32, data word width.
- WORDS_PER_LINE, 40, words per line (1280 px / 32).
- LINES_PER_FRAME, 1024, lines expected before update.
- LINE_GAP, 8, busy cycles after the last word of a line.
- UPDATE_CYCLES, 16, busy cycles after an accepted update.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-high reset.
- data_i  in  DATA_W  line data word.
- sync_i  in  1  one-cycle start-of-line strobe.
- valid_i  in  1  data_i qualifier.
- update_i  in  1  one-cycle end-of-frame / latch strobe.
- clr_err_i  in  1  synchronous clear of err_o.
- next_line_rdy_o  out  1  receiver ready for a new line.
- line_wr_o  out  1  line-buffer write strobe.
- line_addr_o  out  clog2(WORDS_PER_LINE)  word index in the line.
- line_data_o  out  DATA_W  captured word.
- line_cnt_o  out  clog2(LINES_PER_FRAME+1)  lines received in the current frame.
- frame_done_o  out  1  one-cycle pulse on accepted update.
- err_o  out  5  sticky errors: [0] sync, [1] valid, [2] update, [3] short frame, [4] long frame.
- frame_sum_o  out  DATA_W  frame checksum (optional feature).

Behaviour:
- Reset: one clock (clk_i); reset_i is asynchronous, active-high. All outputs reset to 0. State resets to IDLE, counters to 0. next_line_rdy_o asserts on the first clk_i edge after reset release.
- All outputs are registered.
- IDLE (next_line_rdy_o=1):
  - sync_i with line_cnt<LINES_PER_FRAME → LINE; next_line_rdy_o=0 next cycle; word index=0.
  - sync_i with line_cnt==LINES_PER_FRAME → err[4], sync ignored, stay IDLE.
  - update_i → UPDATE; line_cnt cleared. If line_cnt!=LINES_PER_FRAME, set err[3]; frame_done_o still pulses.
  - sync_i and update_i together → update wins, err[0] set.
- LINE: words start the cycle after sync.
  - Each valid_i produces line_wr_o=1 one cycle later, with line_addr_o=index and line_data_o=data_i; index increments.
  - Non-consecutive valid is legal.
  - On the WORDS_PER_LINE-th word → GAP; line_cnt increments in the same cycle as that word's write.
  - sync_i or update_i in LINE → err[0] or err[2] respectively; ignored.
- GAP: count LINE_GAP cycles, then IDLE. next_line_rdy_o rises exactly LINE_GAP+1 cycles after the last word's valid cycle.
- UPDATE: count UPDATE_CYCLES, then IDLE.
- Violations:
  - valid_i in IDLE, GAP, UPDATE, or in the sync cycle → err[1]; word dropped, no write.
  - sync_i in GAP/UPDATE → err[0].
  - update_i in GAP/UPDATE → err[2].
- err_o bits are sticky. clr_err_i clears them next cycle; a new error in the same cycle as clr_err_i wins (bit stays set).
- line_cnt saturates at LINES_PER_FRAME.
- Reset mid-line discards the partial line; no write is emitted.

Optional Feature:
- BLUEJAY_DATA_RX_CHECKSUM_EN defined:
  - frame_sum_o = XOR of every written word since the last update.
  - Registered onto frame_sum_o in the frame_done_o cycle; running accumulator cleared at the same time.
- Undefined: frame_sum_o tied to 0, no accumulator logic.

Decomposition:
- Package bluejay_pkg holds:
  - state enum {IDLE, LINE, GAP, UPDATE};
  - default WORDS_PER_LINE / LINES_PER_FRAME constants;
  - err_o bit index constants.
- One sub-module, bluejay_busy_timer: loadable down-counter with a done flag, shared by GAP and UPDATE.

Test Plan:
All scenarios use WORDS_PER_LINE=4, LINES_PER_FRAME=2, LINE_GAP=3, UPDATE_CYCLES=5.
1. Nominal line: sync, then words 0xA0..0xA3 back-to-back → line_wr_o at addr 0..3 with matching data; line_cnt_o=1; next_line_rdy_o re-asserts 4 cycles after last valid.
2. Full frame: 2 lines, then update in IDLE → frame_done_o pulse, line_cnt_o=0, rdy low 5 cycles, err_o=0; with macro, frame_sum_o = XOR of all 8 words.
3. Short frame: 1 line then update → err_o=5'b01000, frame_done_o still pulses.
4. Violations: valid in GAP → err[1], no write; sync during LINE → err[0]; third sync before update → err[4], no LINE entry; clr_err_i → err_o=0.
5. Gapped valids: words on alternate cycles → 4 writes, correct addresses.
6. Reset asserted after word 2 → all outputs 0 immediately, no further writes; after release, a nominal line is captured correctly.
